// File: rtl/dst40_round_seq.sv
// ---------------------------------------------------------------------------
// dst40_round_seq
//   Control sequencer for the DST40 round datapath (Fe nonlinear function).
//   A start request first pulses the datapath load. The block then issues
//   ROUNDS round-enables and a key-schedule step every KEY_PERIOD rounds.
//   It captures the datapath signature and offers it with a valid/ready
//   handshake. There is no cipher logic in here.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      start request (taken when start & start_ready)
//   start_ready  out  1      high only while idle
//   abort        in   1      cancel the current operation, back to idle
//   dp_load      out  1      one-cycle datapath load pulse
//   dp_round     out  1      datapath performs one round this cycle
//   dp_key_step  out  1      datapath advances its key register this cycle
//   round_idx    out  CW     current round index while running, else 0
//   dp_sig       in   SIG_W  datapath signature, sampled in the capture cycle
//   sig_out      out  SIG_W  buffered signature
//   out_valid    out  1      sig_out is valid
//   out_ready    in   1      consumer takes sig_out when out_valid & out_ready
//   busy         out  1      high in every state except idle
//
// Every output is decoded from registered state and counters only, so there
// is no combinational path from start, abort or out_ready to any output.
// ---------------------------------------------------------------------------
module dst40_round_seq #(
    parameter int ROUNDS     = 200,
    parameter int KEY_PERIOD = 3,
    parameter int SIG_W      = 24,
    parameter int CW         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             start_ready,
    input  logic             abort,
    output logic             dp_load,
    output logic             dp_round,
    output logic             dp_key_step,
    output logic [CW-1:0]    round_idx,
    input  logic [SIG_W-1:0] dp_sig,
    output logic [SIG_W-1:0] sig_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // Phase counter width; a period of 1 still needs a 1-bit register.
    localparam int PW = (KEY_PERIOD > 1) ? $clog2(KEY_PERIOD) : 1;

    localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(KEY_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] round_cnt;
    logic [PW-1:0] phase_cnt;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order the always blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic; abort wins over everything else
    // -----------------------------------------------------------------------
    // NOTE: state_nxt gets its default before the case, so no path through
    // this block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nxt = S_LOAD;
                S_LOAD: state_nxt = S_RUN;
                S_RUN:  if (round_cnt == LAST_ROUND) state_nxt = S_CAPT;
                S_CAPT: state_nxt = S_DONE;
                S_DONE: if (out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Round and key-phase counters
    //   Both counters stay at zero outside RUN. That covers the clear in LOAD
    //   and the clear on abort, and it means RUN always starts from round 0,
    //   phase 0. The round counter never passes LAST_ROUND: on that cycle
    //   the FSM leaves RUN.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt <= '0;
            phase_cnt <= '0;
        end else if (abort || state != S_RUN) begin
            round_cnt <= '0;
            phase_cnt <= '0;
        end else begin
            round_cnt <= (round_cnt == LAST_ROUND) ? '0 : round_cnt + CW'(1);
            phase_cnt <= (phase_cnt == LAST_PHASE) ? '0 : phase_cnt + PW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Signature buffer: loaded once per computation in the capture cycle,
    // then held. An abort in that same cycle leaves the old value in place.
    // -----------------------------------------------------------------------
    // NOTE: this is a single output register, not a memory, so it has an
    // explicit reset value and can be cleared on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_out <= '0;
        end else if (state == S_CAPT && !abort) begin
            sig_out <= dp_sig;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (registered state only)
    // -----------------------------------------------------------------------
    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign dp_load     = (state == S_LOAD);
    assign dp_round    = (state == S_RUN);
    assign dp_key_step = (state == S_RUN) && (phase_cnt == LAST_PHASE);
    assign round_idx   = (state == S_RUN) ? round_cnt : '0;
    assign out_valid   = (state == S_DONE);

endmodule

// File: tb/tb_dst40_round_seq.sv
// ---------------------------------------------------------------------------
// tb_dst40_round_seq
//   Self-checking bench for dst40_round_seq. It runs two instances from the
//   same stimulus: dut_a with the default parameters (200 rounds, key period
//   3) and dut_b with 7 rounds and key period 1.
//
//   The reference model is a timeline. When a start is accepted the model
//   records that edge. Each output is then a plain function of the cycle
//   offset from that edge:
//     offset 0           load
//     offset 1..R        round number offset-1
//     offset R+1         capture
//     offset R+2 onward  signature valid, until handshake or abort
//   A compare process checks every output of both instances on every falling
//   edge. Directed literal checks pin the model to hand-computed numbers:
//   round and key-step counts, the first and last key-step rounds, latency,
//   and signature values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dst40_round_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] dp_sig = 24'h111111;

    logic        a_start_ready, a_dp_load, a_dp_round, a_dp_key_step;
    logic        a_out_valid, a_busy;
    logic [7:0]  a_round_idx;
    logic [23:0] a_sig_out;

    logic        b_start_ready, b_dp_load, b_dp_round, b_dp_key_step;
    logic        b_out_valid, b_busy;
    logic [7:0]  b_round_idx;
    logic [23:0] b_sig_out;

    always #5 clk = ~clk;

    dst40_round_seq #(.ROUNDS(200), .KEY_PERIOD(3), .SIG_W(24), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(a_start_ready),
        .abort(abort), .dp_load(a_dp_load), .dp_round(a_dp_round),
        .dp_key_step(a_dp_key_step), .round_idx(a_round_idx), .dp_sig(dp_sig),
        .sig_out(a_sig_out), .out_valid(a_out_valid), .out_ready(out_ready),
        .busy(a_busy)
    );

    dst40_round_seq #(.ROUNDS(7), .KEY_PERIOD(1), .SIG_W(24), .CW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(b_start_ready),
        .abort(abort), .dp_load(b_dp_load), .dp_round(b_dp_round),
        .dp_key_step(b_dp_key_step), .round_idx(b_round_idx), .dp_sig(dp_sig),
        .sig_out(b_sig_out), .out_valid(b_out_valid), .out_ready(out_ready),
        .busy(b_busy)
    );

    // ---------------------------------------------------------------- checks
    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic int rounds_of(input int i);
        return (i == 0) ? 200 : 7;
    endfunction

    function automatic int kp_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    // ----------------------------------------------------------------- model
    // e counts rising edges taken out of reset. Cycle e is the cycle that
    // follows edge e.
    int          e = 0;
    bit          m_active [2];
    int          m_t0     [2];
    logic [23:0] m_sig    [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0;
                m_sig[i]    = '0;
            end
        end else begin
            e = e + 1;
            for (int i = 0; i < 2; i++) begin
                int k;
                k = e - 1 - m_t0[i];    // offset of the cycle now ending
                if (abort) begin
                    m_active[i] = 1'b0;
                end else if (!m_active[i]) begin
                    if (start) begin
                        m_active[i] = 1'b1;
                        m_t0[i]     = e;
                    end
                end else if (k == rounds_of(i) + 1) begin
                    m_sig[i] = dp_sig;
                end else if (k >= rounds_of(i) + 2 && out_ready) begin
                    m_active[i] = 1'b0;
                end
            end
        end
    end

    task automatic check_dut(input int i, input logic sr, input logic bsy,
                             input logic ld, input logic rd, input logic ks,
                             input logic [7:0] idx, input logic vld,
                             input logic [23:0] sig);
        bit act;
        int k;
        bit x_ld, x_rd, x_ks, x_vld;
        int x_idx;
        act   = m_active[i];
        k     = e - m_t0[i];
        x_ld  = act && (k == 0);
        x_rd  = act && (k >= 1) && (k <= rounds_of(i));
        x_idx = x_rd ? k - 1 : 0;
        x_ks  = x_rd && (((k - 1) % kp_of(i)) == kp_of(i) - 1);
        x_vld = act && (k >= rounds_of(i) + 2);
        check($sformatf("dut%0d start_ready", i), sr, !act);
        check($sformatf("dut%0d busy", i), bsy, act);
        check($sformatf("dut%0d dp_load", i), ld, x_ld);
        check($sformatf("dut%0d dp_round", i), rd, x_rd);
        check($sformatf("dut%0d dp_key_step", i), ks, x_ks);
        check($sformatf("dut%0d round_idx", i), idx, x_idx);
        check($sformatf("dut%0d out_valid", i), vld, x_vld);
        check($sformatf("dut%0d sig_out", i), sig, m_sig[i]);
    endtask

    // Activity counters. The per-run counts restart at each dp_load.
    int load_tot  [2] = '{0, 0};
    int act_tot   [2] = '{0, 0};
    int round_run [2] = '{0, 0};
    int key_run   [2] = '{0, 0};
    int first_key [2] = '{-1, -1};
    int last_key  [2] = '{-1, -1};

    task automatic count_dut(input int i, input logic ld, input logic rd,
                             input logic ks, input logic [7:0] idx);
        if (ld || rd || ks) act_tot[i]++;
        if (ld) begin
            load_tot[i]++;
            round_run[i] = 0;
            key_run[i]   = 0;
            first_key[i] = -1;
        end
        if (rd) round_run[i]++;
        if (ks) begin
            key_run[i]++;
            if (first_key[i] < 0) first_key[i] = int'(idx);
            last_key[i] = int'(idx);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, a_start_ready, a_busy, a_dp_load, a_dp_round,
                      a_dp_key_step, a_round_idx, a_out_valid, a_sig_out);
            check_dut(1, b_start_ready, b_busy, b_dp_load, b_dp_round,
                      b_dp_key_step, b_round_idx, b_out_valid, b_sig_out);
        end
        count_dut(0, a_dp_load, a_dp_round, a_dp_key_step, a_round_idx);
        count_dut(1, b_dp_load, b_dp_round, b_dp_key_step, b_round_idx);
    end

    // ------------------------------------------------------------- stimulus
    // Inputs change 2 ns after the rising edge. Directed checks read outputs
    // at that point too, so after tick() the DUT shows cycle e.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int e0, base, e_v, e_l;

        // 1: reset and idle
        tick(); tick();
        chk_en = 1'b1;
        check("rst start_ready", a_start_ready, 1);
        check("rst busy", a_busy, 0);
        check("rst out_valid", a_out_valid, 0);
        check("rst dp_any", {a_dp_load, a_dp_round, a_dp_key_step}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle start_ready", a_start_ready, 1);
        check("idle busy", a_busy, 0);

        // 2: single run. dp_sig carries the real value only in dut_a's capture
        // cycle: start is high in cycle e0, accepted at edge e0+1, and capture
        // falls 201 cycles after that, in cycle e0+202.
        base = load_tot[0];
        e0 = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (e < e0 + 202) tick();
        dp_sig = 24'hA5C3F0;
        tick();
        dp_sig = 24'h111111;
        for (int n = 0; n < 20 && !a_out_valid; n++) tick();
        check("t2 out_valid", a_out_valid, 1);
        check("t2 latency", e - e0, 203);
        check("t2 sig_out", a_sig_out, 24'hA5C3F0);
        check("t2 loads", load_tot[0] - base, 1);
        check("t2 rounds", round_run[0], 200);
        check("t2 key steps", key_run[0], 66);
        check("t2 first key round", first_key[0], 2);
        check("t2 last key round", last_key[0], 197);
        check("t2 b rounds", round_run[1], 7);
        check("t2 b key steps", key_run[1], 7);

        // 3: backpressure with a stray start that must be ignored
        base = act_tot[0];
        for (int n = 0; n < 50; n++) begin
            start = (n == 10);
            tick();
        end
        start = 1'b0;
        check("t3 no dp activity", act_tot[0] - base, 0);
        check("t3 out_valid held", a_out_valid, 1);
        check("t3 sig_out stable", a_sig_out, 24'hA5C3F0);
        out_ready = 1'b1;
        tick();
        check("t3 out_valid drops", a_out_valid, 0);
        check("t3 back to idle", a_start_ready, 1);

        // 4: abort at round 100, then a clean run
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 300 && !(a_dp_round && a_round_idx == 8'd100); n++) tick();
        check("t4 reached round 100", a_round_idx, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4 abort idle", a_start_ready, 1);
        check("t4 abort busy", a_busy, 0);
        check("t4 abort round_idx", a_round_idx, 0);
        base = act_tot[0];
        for (int n = 0; n < 20; n++) tick();
        check("t4 quiet after abort", act_tot[0] - base, 0);
        dp_sig = 24'h3C3C3C;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 300 && !a_out_valid; n++) tick();
        check("t4 rerun out_valid", a_out_valid, 1);
        check("t4 rerun sig_out", a_sig_out, 24'h3C3C3C);
        check("t4 rerun rounds", round_run[0], 200);

        // 5: abort and out_ready together in DONE
        dp_sig = 24'h5A5A5A;
        out_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5 out_valid", a_out_valid, 0);
        check("t5 sig_out kept", a_sig_out, 24'h3C3C3C);
        check("t5 idle", a_start_ready, 1);

        // 6: short instance, start held high for back-to-back runs
        dp_sig = 24'hC0FFEE;
        start = 1'b1;
        for (int n = 0; n < 50 && !b_out_valid; n++) tick();
        e_v = e;
        check("t6 b out_valid", b_out_valid, 1);
        check("t6 b rounds", round_run[1], 7);
        check("t6 b key steps", key_run[1], 7);
        check("t6 b sig_out", b_sig_out, 24'hC0FFEE);
        tick();
        for (int n = 0; n < 10 && !b_dp_load; n++) tick();
        e_l = e;
        check("t6 b second load", b_dp_load, 1);
        check("t6 b load gap", e_l - e_v, 2);

        // Reset in the middle of dut_a's run: outputs clear at once
        for (int n = 0; n < 20; n++) tick();
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst mid busy", a_busy, 0);
        check("rst mid dp_round", a_dp_round, 0);
        check("rst mid round_idx", a_round_idx, 0);
        check("rst mid start_ready", a_start_ready, 1);
        check("rst mid sig_out", a_sig_out, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post rst idle", a_start_ready, 1);
        check("post rst busy", a_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
